// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display scheduler.
// DISP_SCHED_LOCK_EN adds the post-show LOCK state to the state enum.
package disp_sched_pkg;

  localparam int unsigned TimerWidth        = 8;
  localparam int unsigned ShowCyclesDefault = 8;
  localparam int unsigned LockCyclesDefault = 4;

  typedef enum logic [1:0] {
    StLights = 2'd0,
    StRoll   = 2'd1,
`ifdef DISP_SCHED_LOCK_EN
    StShow   = 2'd2,
    StLock   = 2'd3
`else
    StShow   = 2'd2
`endif
  } sched_state_e;

endpackage

// File: rtl/sched_timer.sv
// Loadable 8-bit down-counter that saturates at zero; load wins over dec.
module sched_timer
  import disp_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [TimerWidth-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  logic [TimerWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates one display between a dice source and a traffic-light source.
// Define DISP_SCHED_LOCK_EN to add a LOCK hold-off after every dice show.
module display_scheduler
  import disp_sched_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = ShowCyclesDefault,
  parameter int unsigned LOCK_CYCLES = LockCyclesDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] dice_val,
  input  logic [2:0] light_val,
  output logic       dice_en,
  output logic       lights_en,
  output logic       sel,
  output logic [2:0] result,
  output logic       show_done
);

  localparam logic [TimerWidth-1:0] ShowLoad = TimerWidth'(SHOW_CYCLES - 1);
`ifdef DISP_SCHED_LOCK_EN
  localparam logic [TimerWidth-1:0] LockLoad = TimerWidth'(LOCK_CYCLES - 1);
`endif

  sched_state_e state_q, state_d;

  logic                  sel_q, sel_d;
  logic                  dice_en_q, dice_en_d;
  logic                  lights_en_q, lights_en_d;
  logic                  show_done_q, show_done_d;
  logic [2:0]            result_q, result_d;

  logic                  tmr_load;
  logic [TimerWidth-1:0] tmr_load_val;
  logic                  tmr_dec;
  logic                  tmr_zero;

  sched_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    show_done_d  = 1'b0;
    case (state_q)
      // lights_en_q is low only in the first cycle after reset, which forces
      // one full LIGHTS cycle before a held button can start a roll.
      StLights: begin
        if (button && lights_en_q) begin
          state_d = StRoll;
        end
      end
      StRoll: begin
        if (!button) begin
          state_d      = StShow;
          tmr_load     = 1'b1;
          tmr_load_val = ShowLoad;
        end
      end
      StShow: begin
        if (button) begin
          state_d = StRoll;
        end else if (tmr_zero) begin
          show_done_d = 1'b1;
`ifdef DISP_SCHED_LOCK_EN
          state_d      = StLock;
          tmr_load     = 1'b1;
          tmr_load_val = LockLoad;
`else
          state_d      = StLights;
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end
`ifdef DISP_SCHED_LOCK_EN
      StLock: begin
        if (tmr_zero) begin
          state_d = StLights;
        end else begin
          tmr_dec = 1'b1;
        end
      end
`endif
      default: state_d = StLights;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    sel_d       = 1'b1;
    dice_en_d   = 1'b0;
    lights_en_d = 1'b1;
    case (state_d)
      StRoll: begin
        sel_d       = 1'b0;
        dice_en_d   = 1'b1;
        lights_en_d = 1'b0;
      end
      StShow: begin
        sel_d       = 1'b0;
        lights_en_d = 1'b0;
      end
      default: ;
    endcase
    result_d = sel_q ? light_val : dice_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StLights;
      sel_q       <= 1'b1;
      dice_en_q   <= 1'b0;
      lights_en_q <= 1'b0;
      show_done_q <= 1'b0;
      result_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      dice_en_q   <= dice_en_d;
      lights_en_q <= lights_en_d;
      show_done_q <= show_done_d;
      result_q    <= result_d;
    end
  end

  assign sel       = sel_q;
  assign dice_en   = dice_en_q;
  assign lights_en = lights_en_q;
  assign show_done = show_done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler in its default build (no LOCK state).
module tb_display_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic [2:0] dice_val = 3'd5;
  logic [2:0] light_val = 3'b100;
  logic       dice_en, lights_en, sel, show_done;
  logic [2:0] result;

  int n_cmp = 0;
  int n_err = 0;

  display_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .dice_val  (dice_val),
    .light_val (light_val),
    .dice_en   (dice_en),
    .lights_en (lights_en),
    .sel       (sel),
    .result    (result),
    .show_done (show_done)
  );

  always #5 clk = ~clk;

  // Traffic-light source: red -> green -> amber -> red, advancing on lights_en.
  always @(posedge clk) begin
    if (lights_en) begin
      case (light_val)
        3'b100:  light_val <= 3'b001;
        3'b001:  light_val <= 3'b010;
        default: light_val <= 3'b100;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_dice, n_sel0, n_lfrz, n_sd, sd_idx;
    logic [2:0] prev;

    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b0;
    #2;
    chk("rst_sel", 8'(sel), 8'd1);
    chk("rst_result", 8'(result), 8'd0);
    chk("rst_lights_en", 8'(lights_en), 8'd0);
    chk("rst_dice_en", 8'(dice_en), 8'd0);
    chk("rst_show_done", 8'(show_done), 8'd0);
    step();
    step();
    chk("rst_held_lights_en", 8'(lights_en), 8'd0);
    rst = 1'b1;

    step();
    chk("post_rst_lights_en", 8'(lights_en), 8'd1);
    chk("post_rst_sel", 8'(sel), 8'd1);
    chk("post_rst_result", 8'(result), 8'b100);
    prev = light_val;
    step();
    chk("lag_result_0", 8'(result), 8'(prev));
    prev = light_val;
    step();
    chk("lag_result_1", 8'(result), 8'(prev));
    chk("lag_result_1_val", 8'(result), 8'b001);

    // Press for 5 sampled edges, then release; light freezes at 100
    button = 1'b1;
    n_dice = 0; n_sel0 = 0; n_lfrz = 0; n_sd = 0; sd_idx = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dice_en) n_dice++;
      if (!sel) n_sel0++;
      if (!lights_en) n_lfrz++;
      if (show_done) begin
        n_sd++;
        sd_idx = i;
      end
      if (i == 0) chk("roll_first_result_light", 8'(result), 8'b010);
      if (i == 1) chk("roll_result_dice", 8'(result), 8'd5);
      if (i == 13) begin
        chk("show_end_sel", 8'(sel), 8'd1);
        chk("show_end_light_frozen", 8'(light_val), 8'b100);
      end
      if (i == 14) chk("resume_result", 8'(result), 8'b100);
      if (i == 4) button = 1'b0;
    end
    chk("dice_en_cycles", 8'(n_dice), 8'd5);
    chk("sel0_cycles", 8'(n_sel0), 8'd13);
    chk("lights_frozen_cycles", 8'(n_lfrz), 8'd13);
    chk("show_done_count", 8'(n_sd), 8'd1);
    chk("show_done_cycle", 8'(sd_idx), 8'd13);

    // Re-press exactly when the SHOW timer reaches zero
    n_sd = 0;
    button = 1'b1;
    step();
    button = 1'b0;
    step();
    if (show_done) n_sd++;
    for (int i = 0; i < 7; i++) begin
      step();
      if (show_done) n_sd++;
    end
    button = 1'b1;
    step();
    if (show_done) n_sd++;
    chk("reroll_dice_en", 8'(dice_en), 8'd1);
    chk("reroll_sel", 8'(sel), 8'd0);
    chk("reroll_no_show_done", 8'(n_sd), 8'd0);

    // Reset mid-ROLL with button held through it
    step();
    #2 rst = 1'b0;
    #1;
    chk("midroll_rst_sel", 8'(sel), 8'd1);
    chk("midroll_rst_dice_en", 8'(dice_en), 8'd0);
    chk("midroll_rst_lights_en", 8'(lights_en), 8'd0);
    chk("midroll_rst_result", 8'(result), 8'd0);
    chk("midroll_rst_show_done", 8'(show_done), 8'd0);
    step();
    step();
    chk("rst_hold_show_done", 8'(show_done), 8'd0);
    rst = 1'b1;
    step();
    chk("held_first_lights_en", 8'(lights_en), 8'd1);
    chk("held_first_dice_en", 8'(dice_en), 8'd0);
    step();
    chk("held_second_dice_en", 8'(dice_en), 8'd1);
    chk("held_second_sel", 8'(sel), 8'd0);

    button = 1'b0;
    n_sd = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (show_done) n_sd++;
    end
    chk("final_show_done_count", 8'(n_sd), 8'd1);
    chk("final_sel", 8'(sel), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter SHOW_CYCLES, default 8, meaning the number of cycles a settled dice value is held on the display after the button is released (legal range 1..255).
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 4, meaning the minimum number of traffic-light display cycles between two dice grants (used only under DISP_SCHED_LOCK_EN; legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port button, input, 1 bit: dice request; held high while rolling.
REQ-006 The block SHALL have port dice_val, input, 3 bits: current dice face from the dice source.
REQ-007 The block SHALL have port light_val, input, 3 bits: current {red, amber, green} from the traffic-light source.
REQ-008 The block SHALL have port dice_en, output, 1 bit: dice source is allowed to advance.
REQ-009 The block SHALL have port lights_en, output, 1 bit: traffic-light source is allowed to advance.
REQ-010 The block SHALL have port sel, output, 1 bit: 0 = dice owns the display, 1 = lights own it.
REQ-011 The block SHALL have port result, output, 3 bits: registered display value.
REQ-012 The block SHALL have port show_done, output, 1 bit: one-cycle pulse when a dice show period ends.

Function
REQ-013 The FSM SHALL have states LIGHTS, ROLL, SHOW and, under DISP_SCHED_LOCK_EN, LOCK; all outputs SHALL be registered.
REQ-014 In LIGHTS: sel=1, lights_en=1, dice_en=0; button=1 -> ROLL next cycle.
REQ-015 In ROLL: sel=0, dice_en=1, lights_en=0 (lights frozen); button=0 -> SHOW and the timer loads SHOW_CYCLES-1.
REQ-016 In SHOW: sel=0, dice_en=0, lights_en=0; the timer decrements once per cycle.
REQ-017 In SHOW, button=1 -> ROLL (re-roll) and SHALL take priority over timer expiry in the same cycle; no show_done pulse is produced.
REQ-018 In SHOW, timer==0 with button=0 -> LIGHTS (or LOCK when enabled), and show_done SHALL pulse high for exactly that one cycle of transition.
REQ-019 result SHALL equal the registered value of (sel ? light_val : dice_val) using the sel of the same cycle, giving one-cycle latency from input to result.
REQ-020 The timer SHALL be 8 bits wide, saturate at 0, and never wrap below zero.
REQ-021 Traffic-light sequence continuity SHALL be preserved: lights_en low freezes the source, so the lights resume from the same phase after a dice show.

Reset
REQ-022 While rst=0: state=LIGHTS, timer=0, sel=1, result=3'b000, dice_en=0, lights_en=0, show_done=0, asynchronously.
REQ-023 lights_en SHALL first go high on the first rising clk edge after rst deasserts; a button held through reset SHALL enter ROLL on the second edge after release (LIGHTS is visited for one cycle).
REQ-024 Reset asserted mid-ROLL or mid-SHOW SHALL abort without a show_done pulse.

Configuration
REQ-025 Macro DISP_SCHED_LOCK_EN defined: SHOW exits to LOCK (sel=1, lights_en=1, dice_en=0, button ignored, timer loaded LOCK_CYCLES-1), and LOCK exits to LIGHTS when timer==0.
REQ-026 Macro DISP_SCHED_LOCK_EN undefined: the LOCK state and LOCK_CYCLES logic SHALL be absent, and SHOW exits directly to LIGHTS.

Structure
REQ-027 Package disp_sched_pkg SHALL hold the state enum, the timer width constant (8), and the default SHOW_CYCLES/LOCK_CYCLES values.
REQ-028 The loadable saturating down-counter SHALL be a sub-module named sched_timer (ports: clk, rst, load, load_val, dec, zero).

Verification
REQ-029 Reset with button=0 -> sel=1, result=000, lights_en=0 during reset; lights_en=1 one cycle after release; result tracks light_val with 1-cycle lag.
REQ-030 button high 5 cycles then low, SHOW_CYCLES=8 -> dice_en high exactly 5 cycles, sel=0 for 13 cycles, show_done pulses once, then sel=1.
REQ-031 button re-pressed at SHOW timer==0 -> state ROLL, no show_done, dice_en=1 next cycle.
REQ-032 light_val=3'b100 frozen during a dice show -> after the show, the lights resume from 3'b100.
REQ-033 With DISP_SCHED_LOCK_EN and LOCK_CYCLES=4, button asserted in the cycle after show_done -> ignored for 4 cycles; ROLL entered on the cycle after LOCK exits to LIGHTS.
REQ-034 rst asserted mid-ROLL -> all outputs at reset values immediately (asynchronously), and no show_done pulse occurs.
